// File: rtl/speicher_arbiter.sv
// speicher_arbiter: round-robin arbiter sharing one memory port between instruction fetch and load/store
module speicher_arbiter #(
  parameter int ADRESSBREITE = 32,
  parameter int DATENBREITE = 32,
  parameter int ZEITLIMIT = 255
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     BefehlAnfrage,
  input  logic [ADRESSBREITE-1:0]  BefehlAdresse,
  output logic [DATENBREITE-1:0]   BefehlDaten,
  output logic                     BefehlGeladen,
  input  logic                     DatenAnfrage,
  input  logic                     DatenSchreiben,
  input  logic [ADRESSBREITE-1:0]  DatenAdresse,
  input  logic [DATENBREITE-1:0]   DatenSchreibDaten,
  input  logic [DATENBREITE/8-1:0] DatenByteMaske,
  output logic [DATENBREITE-1:0]   DatenLeseDaten,
  output logic                     DatenGeladen,
  output logic                     DatenGespeichert,
  output logic                     SpeicherAnfrage,
  output logic                     SpeicherSchreiben,
  output logic [ADRESSBREITE-1:0]  SpeicherAdresse,
  output logic [DATENBREITE-1:0]   SpeicherSchreibDaten,
  output logic [DATENBREITE/8-1:0] SpeicherByteMaske,
  input  logic [DATENBREITE-1:0]   SpeicherLeseDaten,
  input  logic                     SpeicherFertig,
  output logic                     Fehler,
  output logic [1:0]               status
);
  localparam int ZB = $clog2(ZEITLIMIT);
  typedef enum logic [1:0] {IDLE = 2'b00, BEFEHL = 2'b01, DATEN = 2'b10, ABSCHLUSS = 2'b11} state_t;
  state_t state;
  logic [ZB-1:0] cnt;
  logic last_daten;
  logic grant_befehl, grant_daten, timeout, store;
  assign grant_befehl = BefehlAnfrage & (~DatenAnfrage | last_daten);
  assign grant_daten = DatenAnfrage & ~grant_befehl;
  assign timeout = cnt == ZB'(ZEITLIMIT - 1);
  assign store = grant_daten & DatenSchreiben;
  assign SpeicherAnfrage = state == BEFEHL || state == DATEN;
  assign status = state;
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      cnt <= '0;
      last_daten <= 1'b1;
      BefehlDaten <= '0;
      BefehlGeladen <= 1'b0;
      DatenLeseDaten <= '0;
      DatenGeladen <= 1'b0;
      DatenGespeichert <= 1'b0;
      SpeicherSchreiben <= 1'b0;
      SpeicherAdresse <= '0;
      SpeicherSchreibDaten <= '0;
      SpeicherByteMaske <= '0;
      Fehler <= 1'b0;
    end else begin
      BefehlGeladen <= 1'b0;
      DatenGeladen <= 1'b0;
      DatenGespeichert <= 1'b0;
      Fehler <= 1'b0;
      case (state)
        IDLE: if (grant_befehl || grant_daten) begin
          state <= grant_befehl ? BEFEHL : DATEN;
          last_daten <= grant_daten;
          cnt <= '0;
          SpeicherAdresse <= grant_befehl ? BefehlAdresse : DatenAdresse;
          SpeicherSchreiben <= store;
          SpeicherSchreibDaten <= DatenSchreibDaten;
          SpeicherByteMaske <= store ? DatenByteMaske : '1;
        end
        BEFEHL, DATEN: if (SpeicherFertig || timeout) begin
          // a timed-out read returns zero; Fertig on the last wait cycle still counts as success
          state <= ABSCHLUSS;
          Fehler <= ~SpeicherFertig;
          if (state == BEFEHL) begin
            BefehlGeladen <= 1'b1;
            BefehlDaten <= SpeicherFertig ? SpeicherLeseDaten : '0;
          end else if (SpeicherSchreiben) begin
            DatenGespeichert <= 1'b1;
          end else begin
            DatenGeladen <= 1'b1;
            DatenLeseDaten <= SpeicherFertig ? SpeicherLeseDaten : '0;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_speicher_arbiter.sv
// tb_speicher_arbiter: directed vectors with hand-computed expectations for speicher_arbiter
module tb_speicher_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic b_req = 0, d_req = 0, d_we = 0, m_rdy = 0;
  logic [31:0] b_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
  logic [3:0] d_mask = 0;
  logic [31:0] b_data, d_rdata, m_addr, m_wdata;
  logic [3:0] m_mask;
  logic b_done, d_done, d_stored, m_req, m_we, err;
  logic [1:0] st;
  int n_chk = 0, n_pass = 0;

  speicher_arbiter #(.ADRESSBREITE(32), .DATENBREITE(32), .ZEITLIMIT(4)) dut (
    .Clock(clk), .Reset(rst_n),
    .BefehlAnfrage(b_req), .BefehlAdresse(b_addr), .BefehlDaten(b_data), .BefehlGeladen(b_done),
    .DatenAnfrage(d_req), .DatenSchreiben(d_we), .DatenAdresse(d_addr), .DatenSchreibDaten(d_wdata),
    .DatenByteMaske(d_mask), .DatenLeseDaten(d_rdata), .DatenGeladen(d_done), .DatenGespeichert(d_stored),
    .SpeicherAnfrage(m_req), .SpeicherSchreiben(m_we), .SpeicherAdresse(m_addr),
    .SpeicherSchreibDaten(m_wdata), .SpeicherByteMaske(m_mask), .SpeicherLeseDaten(m_rdata),
    .SpeicherFertig(m_rdy), .Fehler(err), .status(st)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_status", 32'(st), 0);
    chk("rst_mreq", 32'(m_req), 0);
    chk("rst_mask", 32'(m_mask), 0);
    chk("rst_bdata", b_data, 0);
    rst_n = 1;
    // instruction fetch, memory ready immediately
    b_req = 1; b_addr = 32'h100; m_rdy = 1; m_rdata = 32'hDEADBEEF;
    chk("f_c0_status", 32'(st), 0);
    tick();
    chk("f_c1_status", 32'(st), 1);
    chk("f_c1_mreq", 32'(m_req), 1);
    chk("f_c1_addr", m_addr, 32'h100);
    chk("f_c1_we", 32'(m_we), 0);
    chk("f_c1_mask", 32'(m_mask), 4'hF);
    tick();
    chk("f_c2_status", 32'(st), 3);
    chk("f_c2_done", 32'(b_done), 1);
    chk("f_c2_data", b_data, 32'hDEADBEEF);
    chk("f_c2_err", 32'(err), 0);
    b_req = 0; m_rdy = 0;
    tick();
    chk("f_c3_status", 32'(st), 0);
    chk("f_c3_done", 32'(b_done), 0);
    chk("f_c3_hold", b_data, 32'hDEADBEEF);
    // store with three wait cycles
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h12345678; d_mask = 4'b0011;
    tick();
    chk("s_addr", m_addr, 32'h40);
    chk("s_wdata", m_wdata, 32'h12345678);
    for (int i = 0; i < 4; i++) begin
      chk("s_status", 32'(st), 2);
      chk("s_we", 32'(m_we), 1);
      chk("s_mask", 32'(m_mask), 4'b0011);
      chk("s_nopulse", 32'(d_stored), 0);
      if (i == 3) m_rdy = 1;
      tick();
    end
    chk("s_stored", 32'(d_stored), 1);
    chk("s_loaded", 32'(d_done), 0);
    chk("s_err", 32'(err), 0);
    chk("s_drd", d_rdata, 0);
    chk("s_brd", b_data, 32'hDEADBEEF);
    d_req = 0; d_we = 0; m_rdy = 0;
    tick();
    chk("s_idle", 32'(st), 0);
    // both requesters held: B, D, B
    b_req = 1; b_addr = 32'h200; d_req = 1; d_addr = 32'h80; m_rdy = 1;
    for (int k = 0; k < 3; k++) begin
      m_rdata = 32'hA0000000 + 32'(k);
      tick();
      chk("rr_status", 32'(st), (k == 1) ? 2 : 1);
      chk("rr_addr", m_addr, (k == 1) ? 32'h80 : 32'h200);
      chk("rr_mask", 32'(m_mask), 4'hF);
      tick();
      chk("rr_bdone", 32'(b_done), (k == 1) ? 0 : 1);
      chk("rr_ddone", 32'(d_done), (k == 1) ? 1 : 0);
      if (k == 1) chk("rr_drd", d_rdata, 32'hA0000001);
      else chk("rr_brd", b_data, 32'hA0000000 + 32'(k));
      tick();
      chk("rr_idle", 32'(st), 0);
    end
    b_req = 0; d_req = 0; m_rdy = 0;
    tick();
    // load timeout with ZEITLIMIT=4
    d_req = 1; d_addr = 32'h44;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t_wait", 32'(d_done | err), 0);
    end
    tick();
    chk("t_done", 32'(d_done), 1);
    chk("t_err", 32'(err), 1);
    chk("t_data", d_rdata, 0);
    d_req = 0;
    tick();
    chk("t_err_clr", 32'(err), 0);
    chk("t_idle", 32'(st), 0);
    // Fertig on the final wait cycle wins over timeout
    d_req = 1; m_rdata = 32'h5555AAAA;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) m_rdy = 1;
    end
    tick();
    chk("l_done", 32'(d_done), 1);
    chk("l_err", 32'(err), 0);
    chk("l_data", d_rdata, 32'h5555AAAA);
    d_req = 0; m_rdy = 0;
    tick();
    // reset during a data wait
    d_req = 1; d_addr = 32'h48;
    tick();
    chk("r_daten", 32'(st), 2);
    tick();
    #2 rst_n = 0;
    #1;
    chk("r_mreq", 32'(m_req), 0);
    chk("r_status", 32'(st), 0);
    chk("r_drd", d_rdata, 0);
    chk("r_brd", b_data, 0);
    b_req = 1; b_addr = 32'h300;
    tick();
    chk("r_nopulse", 32'(d_done), 0);
    rst_n = 1;
    tick();
    chk("r_grant_b", 32'(st), 1);
    chk("r_addr", m_addr, 32'h300);
    m_rdy = 1; m_rdata = 32'h0BADF00D;
    tick();
    chk("r_bdone", 32'(b_done), 1);
    chk("r_bdata", b_data, 32'h0BADF00D);
    b_req = 0; d_req = 0; m_rdy = 0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/speicher_arbiter.md
# speicher_arbiter

Two-port memory arbiter between the processor's instruction-fetch path and its load/store data path. It shares a single request/ready memory port. The controller's fetch phase drives the instruction port; the load and store writeback phases drive the data port. The arbiter grants one requester at a time, presents the latched transaction to memory, returns read data with a one-cycle completion pulse, and aborts transactions that exceed a cycle limit.

## Interface
Parameters:
- ADRESSBREITE, 32, address width of all ports
- DATENBREITE, 32, data width; byte mask width is DATENBREITE/8
- ZEITLIMIT, 255, max cycles a granted transaction waits for SpeicherFertig (≥2)

Ports:
- Clock  in  1  single clock, all state on rising edge
- Reset  in  1  asynchronous, active-low; all state cleared while low
- BefehlAnfrage  in  1  instruction read request, level, held until BefehlGeladen
- BefehlAdresse  in  ADRESSBREITE  instruction address, stable while BefehlAnfrage
- BefehlDaten  out  DATENBREITE  fetched instruction, valid with BefehlGeladen, held until next completion
- BefehlGeladen  out  1  one-cycle completion pulse, instruction port
- DatenAnfrage  in  1  data request, level, held until completion pulse
- DatenSchreiben  in  1  1 = store, 0 = load
- DatenAdresse  in  ADRESSBREITE  data address
- DatenSchreibDaten  in  DATENBREITE  store data
- DatenByteMaske  in  DATENBREITE/8  store byte enables
- DatenLeseDaten  out  DATENBREITE  load result, valid with DatenGeladen
- DatenGeladen  out  1  one-cycle load completion pulse
- DatenGespeichert  out  1  one-cycle store completion pulse
- SpeicherAnfrage  out  1  memory request, high throughout BEFEHL/DATEN
- SpeicherSchreiben  out  1  memory write enable
- SpeicherAdresse  out  ADRESSBREITE  latched address
- SpeicherSchreibDaten  out  DATENBREITE  latched store data
- SpeicherByteMaske  out  DATENBREITE/8  latched mask; all ones for reads
- SpeicherLeseDaten  in  DATENBREITE  memory read data, sampled when SpeicherFertig
- SpeicherFertig  in  1  memory completes the current request this cycle
- Fehler  out  1  one-cycle pulse with the completion pulse of a timed-out transaction
- status  out  2  current state encoding

## Operation
- States:
  - IDLE=2'b00: no transaction granted.
  - BEFEHL=2'b01: instruction read in progress.
  - DATEN=2'b10: data load or store in progress.
  - ABSCHLUSS=2'b11: completion cycle.
- IDLE transitions:
  - Only BefehlAnfrage high: go to BEFEHL.
  - Only DatenAnfrage high: go to DATEN.
  - Both high: round-robin. Grant the port not granted last. Last-granted flag resets to "Daten", so instruction wins the first tie.
  - Neither high: stay in IDLE.
- On the grant edge, latch address, write flag, store data and mask into the Speicher* registers.
  - Instruction grants force SpeicherSchreiben=0 and mask all ones.
  - Data loads force mask all ones.
- BEFEHL/DATEN:
  - SpeicherAnfrage=1.
  - Cycle counter cleared on entry, increments each cycle without SpeicherFertig.
- SpeicherFertig=1:
  - Latch SpeicherLeseDaten into the granted port's read register. Stores leave read registers unchanged.
  - Go to ABSCHLUSS.
- Timeout: counter == ZEITLIMIT-1 with SpeicherFertig=0.
  - Go to ABSCHLUSS with the error flag set. A load or instruction read register gets 0.
  - SpeicherFertig and timeout in the same cycle: SpeicherFertig wins, no Fehler.
- ABSCHLUSS:
  - Assert exactly one of BefehlGeladen / DatenGeladen / DatenGespeichert. Assert Fehler if the error flag is set.
  - Unconditionally return to IDLE.
- No new grant in ABSCHLUSS. A request still high in IDLE counts as a new request.
- Reset low, at any time including mid-transaction:
  - State IDLE.
  - All outputs 0, including read registers, Speicher* registers and status.
  - Last-granted flag = Daten.
  - The in-flight memory request is dropped immediately.

## Timing
- All outputs are registered or decoded from state. No combinational path from SpeicherFertig or the request inputs to any output.
- Minimum latency, request to completion pulse:
  - Cycle 0: request seen in IDLE.
  - Cycle 1: SpeicherAnfrage high, memory returns Fertig.
  - Cycle 2: completion pulse.
- Each extra memory wait cycle adds one cycle.
- Timeout: the completion pulse with Fehler appears ZEITLIMIT+1 cycles after the grant cycle.
- The requester must drop its request on the edge that ends ABSCHLUSS. Back-to-back transactions are therefore spaced at least 3 cycles apart.
- Speicher* address/data/mask hold their last values in IDLE. Only SpeicherAnfrage qualifies them.

## Test plan
- Reset release, BefehlAnfrage=1, addr 0x100, memory Fertig in first cycle with data 0xDEADBEEF → SpeicherAnfrage in cycle 1; BefehlGeladen with BefehlDaten=0xDEADBEEF in cycle 2; status 00→01→11→00.
- Store addr 0x40, data 0x12345678, mask 4'b0011, Fertig after 3 wait cycles → SpeicherSchreiben=1, mask 0011 for 4 cycles; DatenGespeichert pulse one cycle later; read registers unchanged.
- Both requests held continuously, each transaction completing → grants alternate Befehl, Daten, Befehl. First grant is Befehl after reset.
- ZEITLIMIT=4, load with SpeicherFertig never asserted → DatenGeladen and Fehler pulse together 5 cycles after grant; DatenLeseDaten=0. Repeat with Fertig in the final wait cycle → no Fehler.
- Reset low during DATEN wait → SpeicherAnfrage falls without a clock edge; no completion pulse; after release, a pending BefehlAnfrage is granted first.
